mem_lsu_port: RTL and testbench
===============================

Name: mem_lsu_port

Overview:
- Initiator side of the synchronous single-port SRAM interface: `addr`, `wdata`, byte `wen`, and `rdata` returned one cycle later.
- Accepts byte-addressed load/store requests from a core over a valid/ready channel.
- Converts each request to a word address, byte enables and lane-replicated write data; aligns and sign/zero-extends load data.
- Returns one response per request over a second valid/ready channel.
- Sits between the core's load/store stage and the data memory.

Parameters:
- DATA_WIDTH, 32, memory word width; legal values 32 or 64.
- DATA_BYTES, DATA_WIDTH/8, number of byte lanes.
- ADDR_WIDTH, 11, memory word-address width.
- OFF_WIDTH, $clog2(DATA_BYTES), byte-offset bits inside a word.
- BADDR_WIDTH, ADDR_WIDTH+OFF_WIDTH, request byte-address width.

Ports:
- clk  in  1  clock; everything sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_addr  in  BADDR_WIDTH  byte address.
- i_req_we  in  1  1=store, 0=load.
- i_req_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_WIDTH=64).
- i_req_signed  in  1  sign-extend load result.
- i_req_wdata  in  DATA_WIDTH  store data, right-aligned.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when valid&ready.
- o_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  request rejected; no memory write performed.
- o_mem_addr  out  ADDR_WIDTH  word address to memory.
- o_mem_wdata  out  DATA_WIDTH  write data to memory.
- o_mem_wen  out  DATA_BYTES  per-byte write enables.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0; internal addr_q=0; o_mem_wen=0.
- States: IDLE, RD_WAIT, RSP.
- o_req_ready = (state==IDLE), combinational; at most one request in flight.
- IDLE, no valid:
  - o_mem_addr=addr_q, o_mem_wen=0.
- IDLE, i_req_valid=1:
  - o_mem_addr = i_req_addr[BADDR_WIDTH-1:OFF_WIDTH], combinational.
  - Latch word address into addr_q, plus offset, size, signed.
  - Error request (illegal size, or misaligned per Optional Feature): o_mem_wen=0, rsp_err<=1, rsp_rdata<=0, go RSP.
  - Store: o_mem_wen = lane mask << offset in the same cycle; rsp_rdata<=0, go RSP.
  - Load: o_mem_wen=0, go RD_WAIT.
- RD_WAIT (exactly 1 cycle):
  - o_mem_addr=addr_q, held stable; the memory's bank read mux decodes the live address.
  - rsp_rdata <= extend((i_mem_rdata >> 8*offset) masked to size); go RSP.
- RSP:
  - o_rsp_valid=1; data and err held stable until i_rsp_ready.
  - On i_rsp_ready: o_rsp_valid<=0, go IDLE.
  - o_mem_addr=addr_q, o_mem_wen=0.
- Latency:
  - Store: response visible 1 cycle after accept.
  - Load: response visible 2 cycles after accept.
  - Minimum request spacing: 2 cycles for stores, 3 for loads.
- Lane masks: byte=1, half=3, word=0xF, dword=0xFF.
- o_mem_wdata replication: byte replicated to every lane, half to every half, word to every word; dword passed through.
- Extension: signed → replicate the top bit of the selected size; unsigned → zero-fill. Sizes equal to DATA_WIDTH are passed unchanged.
- Illegal size: size 3 with DATA_WIDTH=32 always gives err=1, regardless of macro.
- Reset mid-operation: rst in RD_WAIT/RSP discards the response and returns to IDLE; o_mem_wen=0 during the rst cycle; memory contents already written are unaffected.
- i_rsp_ready while o_rsp_valid=0: ignored.

Optional Feature:
- MEM_LSU_MISALIGN_ERR_EN defined:
  - A request whose offset is not a multiple of its size (half: off[0]!=0; word: off[1:0]!=0; dword: off!=0) is rejected with err=1 and no write.
- Not defined:
  - Misaligned offsets are force-aligned by clearing the low log2(size) offset bits.
  - The access proceeds normally and err is only set for illegal size.

Test Plan:
- Reset:
  - Assert rst 2 cycles during a load in RD_WAIT → o_rsp_valid=0, o_mem_wen=0, o_req_ready=1 the cycle after rst falls.
- Byte store, DATA_WIDTH=32:
  - Addr 0x0006, size 0, wdata 0x000000A5 → o_mem_addr=0x001, o_mem_wen=4'b0100, o_mem_wdata=0xA5A5A5A5.
  - Response (err=0, rdata=0) one cycle later.
- Signed half load:
  - Word 0x001 holds 0x8001_7FFF; load addr 0x0006, size 1, signed → o_rsp_rdata=0xFFFF8001 two cycles after accept.
  - Same load unsigned → 0x00008001.
- Backpressure:
  - Hold i_rsp_ready=0 for 5 cycles after a load → o_rsp_valid and rdata stable, o_req_ready=0, o_mem_addr=addr_q throughout.
  - Release → IDLE next cycle.
- Misaligned word store at 0x0005:
  - With MEM_LSU_MISALIGN_ERR_EN: err=1, o_mem_wen=0.
  - Without: o_mem_addr=0x001, o_mem_wen=4'hF, err=0.
- DATA_WIDTH=64:
  - Dword store 0x0123456789ABCDEF at 0x0008 → o_mem_wen=8'hFF.
  - Reload → same value; size 3 on a DATA_WIDTH=32 build → err=1.

Source files
------------

// File: rtl/mem_lsu_port.sv
// Load/store adapter between a core's valid/ready request channel and a single-port SRAM.
// Define MEM_LSU_MISALIGN_ERR_EN to reject misaligned accesses instead of force-aligning them.
module mem_lsu_port #(
   parameter int DATA_WIDTH  = 32,
   parameter int DATA_BYTES  = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH  = 11,
   parameter int OFF_WIDTH   = $clog2(DATA_BYTES),
   parameter int BADDR_WIDTH = ADDR_WIDTH + OFF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic [BADDR_WIDTH-1:0] i_req_addr,
   input  logic                   i_req_we,
   input  logic [1:0]             i_req_size,
   input  logic                   i_req_signed,
   input  logic [DATA_WIDTH-1:0]  i_req_wdata,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [DATA_WIDTH-1:0]  o_rsp_rdata,
   output logic                   o_rsp_err,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [DATA_WIDTH-1:0]  o_mem_wdata,
   output logic [DATA_BYTES-1:0]  o_mem_wen,
   input  logic [DATA_WIDTH-1:0]  i_mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RSP
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [OFF_WIDTH-1:0]    off_q;
   logic [1:0]              size_q;
   logic                    signed_q;
   logic                    rsp_valid_q;
   logic                    rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [DATA_WIDTH-1:0]   rdata_d;

   logic                    acceptReq;
   logic [ADDR_WIDTH-1:0]   reqWordAddr;
   logic [OFF_WIDTH-1:0]    reqOff;
   logic [OFF_WIDTH-1:0]    alignKeep;
   logic [OFF_WIDTH-1:0]    offEff;
   logic                    sizeIllegal;
   logic                    reqErr;
   logic [DATA_BYTES-1:0]   laneMask;
   logic [DATA_WIDTH-1:0]   memWdata;
   logic [DATA_WIDTH-1:0]   shifted;
   logic                    signBit;
   int                      keepBits;

   assign acceptReq   = (state_q == IDLE) && i_req_valid;
   assign reqWordAddr = i_req_addr[BADDR_WIDTH-1:OFF_WIDTH];
   assign reqOff      = i_req_addr[OFF_WIDTH-1:0];

   // Offset bits below the access size are dropped; an aligned offset passes unchanged.
   assign alignKeep   = {OFF_WIDTH{1'b1}} << i_req_size;
   assign offEff      = reqOff & alignKeep;
   assign sizeIllegal = (i_req_size == 2'd3) && (DATA_WIDTH != 64);

`ifdef MEM_LSU_MISALIGN_ERR_EN
   logic misaligned;
   assign misaligned = |(reqOff & ~alignKeep);
   assign reqErr     = sizeIllegal | misaligned;
`else
   assign reqErr     = sizeIllegal;
`endif

   always_comb begin
      laneMask = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         laneMask[i] = (i < (1 << i_req_size));
      end
   end

   // Replicate right-aligned store data so every lane the access may hit carries it.
   always_comb begin
      memWdata = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         case (i_req_size)
            2'd0:    memWdata[8*i +: 8] = i_req_wdata[7:0];
            2'd1:    memWdata[8*i +: 8] = i_req_wdata[8*(i%2) +: 8];
            2'd2:    memWdata[8*i +: 8] = i_req_wdata[8*(i%4) +: 8];
            default: memWdata[8*i +: 8] = i_req_wdata[8*i +: 8];
         endcase
      end
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_mem_addr  = acceptReq ? reqWordAddr : addr_q;
   assign o_mem_wdata = memWdata;
   assign o_mem_wen   = (acceptReq && i_req_we && !reqErr && !rst) ? (laneMask << offEff) : '0;

   // Load alignment: shift the selected lanes down, then sign- or zero-fill above the size.
   assign shifted = i_mem_rdata >> {off_q, 3'b000};

   always_comb begin
      rdata_d  = '0;
      signBit  = 1'b0;
      keepBits = DATA_WIDTH;
      case (size_q)
         2'd0: begin
            keepBits = 8;
            signBit  = shifted[7];
         end
         2'd1: begin
            keepBits = 16;
            signBit  = shifted[15];
         end
         2'd2: begin
            keepBits = 32;
            signBit  = shifted[31];
         end
         default: begin
            keepBits = DATA_WIDTH;
            signBit  = 1'b0;
         end
      endcase
      for (int i = 0; i < DATA_WIDTH; i++) begin
         rdata_d[i] = (i < keepBits) ? shifted[i] : (signed_q & signBit);
      end
   end

   // Control FSM with registered response outputs; one request in flight at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_req_valid) begin
                  addr_q      <= reqWordAddr;
                  off_q       <= offEff;
                  size_q      <= i_req_size;
                  signed_q    <= i_req_signed;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= reqErr;
                  if (reqErr || i_req_we) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RSP;
                  end else begin
                     state_q     <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               rsp_rdata_q <= rdata_d;
               rsp_valid_q <= 1'b1;
               state_q     <= RSP;
            end
            RSP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Self-checking bench for mem_lsu_port: 32-bit and 64-bit instances sharing one request driver,
// each backed by a byte-writable synchronous SRAM model.
module tb_mem_lsu_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid;
   logic        reqWe;
   logic        reqSigned;
   logic        rspReady;
   logic [1:0]  reqSize;
   logic [13:0] reqAddr;
   logic [63:0] reqWdata;
   logic        use64;

   logic        v32, v64, rr32, rr64;
   logic        r32Ready, r32Valid, r32Err;
   logic [31:0] r32Rdata, m32Wdata, m32Rdata;
   logic [10:0] m32Addr;
   logic [3:0]  m32Wen;
   logic        r64Ready, r64Valid, r64Err;
   logic [63:0] r64Rdata, m64Wdata, m64Rdata;
   logic [10:0] m64Addr;
   logic [7:0]  m64Wen;

   logic        curReqReady, curRspValid, curRspErr;
   logic [63:0] curRspRdata, curMemWdata;
   logic [10:0] curMemAddr;
   logic [7:0]  curMemWen;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          addr;
      bit          we;
      int          size;
      bit          sgn;
      logic [63:0] wdata;
      int          expMemAddr;
      int          expWen;
      logic [63:0] expWdata;
      logic [63:0] expRdata;
      bit          expErr;
      int          expLat;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      bit          err;
      int          lat;
   } rsp_t;

   vec_t vec32[$];
   vec_t vec64[$];
   rsp_t sbQ[$];
   logic [63:0] oldWord;

   always #5 clk = ~clk;

   assign v32  = reqValid && !use64;
   assign v64  = reqValid && use64;
   assign rr32 = rspReady && !use64;
   assign rr64 = rspReady && use64;

   mem_lsu_port #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst),
      .i_req_valid(v32), .o_req_ready(r32Ready), .i_req_addr(reqAddr[12:0]),
      .i_req_we(reqWe), .i_req_size(reqSize), .i_req_signed(reqSigned),
      .i_req_wdata(reqWdata[31:0]),
      .o_rsp_valid(r32Valid), .i_rsp_ready(rr32), .o_rsp_rdata(r32Rdata), .o_rsp_err(r32Err),
      .o_mem_addr(m32Addr), .o_mem_wdata(m32Wdata), .o_mem_wen(m32Wen), .i_mem_rdata(m32Rdata)
   );

   mem_lsu_port #(.DATA_WIDTH(64)) dut64 (
      .clk(clk), .rst(rst),
      .i_req_valid(v64), .o_req_ready(r64Ready), .i_req_addr(reqAddr),
      .i_req_we(reqWe), .i_req_size(reqSize), .i_req_signed(reqSigned),
      .i_req_wdata(reqWdata),
      .o_rsp_valid(r64Valid), .i_rsp_ready(rr64), .o_rsp_rdata(r64Rdata), .o_rsp_err(r64Err),
      .o_mem_addr(m64Addr), .o_mem_wdata(m64Wdata), .o_mem_wen(m64Wen), .i_mem_rdata(m64Rdata)
   );

   assign curReqReady = use64 ? r64Ready : r32Ready;
   assign curRspValid = use64 ? r64Valid : r32Valid;
   assign curRspErr   = use64 ? r64Err   : r32Err;
   assign curRspRdata = use64 ? r64Rdata : {32'h0, r32Rdata};
   assign curMemWdata = use64 ? m64Wdata : {32'h0, m32Wdata};
   assign curMemAddr  = use64 ? m64Addr  : m32Addr;
   assign curMemWen   = use64 ? m64Wen   : {4'h0, m32Wen};

   // SRAM models: byte writes and a registered read of the presented address.
   logic [31:0] mem32 [2048];
   logic [63:0] mem64 [2048];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (m32Wen[b]) mem32[m32Addr][8*b +: 8] <= m32Wdata[8*b +: 8];
      end
      m32Rdata <= mem32[m32Addr];
   end

   always @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (m64Wen[b]) mem64[m64Addr][8*b +: 8] <= m64Wdata[8*b +: 8];
      end
      m64Rdata <= mem64[m64Addr];
   end

   function automatic vec_t mk(input int a, input bit we, input int sz, input bit sg,
                               input logic [63:0] wd, input int ma, input int wen,
                               input logic [63:0] mwd, input logic [63:0] rd,
                               input bit err, input int lat);
      vec_t v;
      v.addr = a; v.we = we; v.size = sz; v.sgn = sg; v.wdata = wd;
      v.expMemAddr = ma; v.expWen = wen; v.expWdata = mwd;
      v.expRdata = rd; v.expErr = err; v.expLat = lat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pops the scoreboard once a response is (or should be) visible, then completes the handshake.
   task automatic collectResponse(input string name, input int lat);
      rsp_t exp;
      exp = sbQ.pop_front();
      checkOutput({name, " rsp_valid"}, 64'(curRspValid), 64'(1));
      checkOutput({name, " latency"}, 64'(lat), 64'(exp.lat));
      checkOutput({name, " rdata"}, curRspRdata, exp.rdata);
      checkOutput({name, " err"}, 64'(curRspErr), 64'(exp.err));
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      checkOutput({name, " valid after ack"}, 64'(curRspValid), 64'(0));
      checkOutput({name, " ready after ack"}, 64'(curReqReady), 64'(1));
   endtask

   task automatic driveReq(input vec_t v);
      reqValid  = 1'b1;
      reqAddr   = 14'(v.addr);
      reqWe     = v.we;
      reqSize   = 2'(v.size);
      reqSigned = v.sgn;
      reqWdata  = v.wdata;
   endtask

   task automatic waitRsp(output int lat);
      lat = 1;
      while (!curRspValid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic applyStimulus(input string name, input vec_t v);
      int lat;
      @(posedge clk); #1;
      driveReq(v);
      #1;
      checkOutput({name, " req_ready"}, 64'(curReqReady), 64'(1));
      checkOutput({name, " mem_addr"}, 64'(curMemAddr), 64'(v.expMemAddr));
      checkOutput({name, " mem_wen"}, 64'(curMemWen), 64'(v.expWen));
      if (v.expWen != 0) checkOutput({name, " mem_wdata"}, curMemWdata, v.expWdata);
      sbQ.push_back('{rdata: v.expRdata, err: v.expErr, lat: v.expLat});
      @(posedge clk); #1;
      reqValid = 1'b0;
      waitRsp(lat);
      collectResponse(name, lat);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      vec_t bp;
      rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSigned = 1'b0; rspReady = 1'b0;
      reqSize = 2'd0; reqAddr = '0; reqWdata = '0; use64 = 1'b0;

      vec32.push_back(mk('h006, 1, 0, 0, 64'hA5,       1, 'h4, 64'hA5A5A5A5, 64'h0, 0, 1));
      vec32.push_back(mk('h004, 1, 2, 0, 64'h80017FFF, 1, 'hF, 64'h80017FFF, 64'h0, 0, 1));
      vec32.push_back(mk('h006, 0, 1, 1, 64'h0,        1, 0,   64'h0, 64'hFFFF8001, 0, 2));
      vec32.push_back(mk('h006, 0, 1, 0, 64'h0,        1, 0,   64'h0, 64'h00008001, 0, 2));
      vec32.push_back(mk('h004, 0, 0, 1, 64'h0,        1, 0,   64'h0, 64'hFFFFFFFF, 0, 2));
      vec32.push_back(mk('h005, 0, 0, 1, 64'h0,        1, 0,   64'h0, 64'h0000007F, 0, 2));
      vec32.push_back(mk('h007, 0, 0, 0, 64'h0,        1, 0,   64'h0, 64'h00000080, 0, 2));
      vec32.push_back(mk('h008, 1, 2, 0, 64'hCAFEF00D, 2, 'hF, 64'hCAFEF00D, 64'h0, 0, 1));
      vec32.push_back(mk('h00A, 1, 1, 0, 64'h1234,     2, 'hC, 64'h12341234, 64'h0, 0, 1));
      vec32.push_back(mk('h008, 0, 2, 0, 64'h0,        2, 0,   64'h0, 64'h1234F00D, 0, 2));
      vec32.push_back(mk('h008, 0, 1, 1, 64'h0,        2, 0,   64'h0, 64'hFFFFF00D, 0, 2));
      vec32.push_back(mk('h010, 1, 2, 0, 64'h11223344, 4, 'hF, 64'h11223344, 64'h0, 0, 1));
      vec32.push_back(mk('h010, 1, 3, 0, 64'hFFFFFFFF, 4, 0,   64'h0, 64'h0, 1, 1));
      vec32.push_back(mk('h010, 0, 3, 1, 64'h0,        4, 0,   64'h0, 64'h0, 1, 1));
      vec32.push_back(mk('h010, 0, 2, 0, 64'h0,        4, 0,   64'h0, 64'h11223344, 0, 2));
`ifdef MEM_LSU_MISALIGN_ERR_EN
      vec32.push_back(mk('h005, 1, 2, 0, 64'hDEADBEEF, 1, 0,   64'h0, 64'h0, 1, 1));
      vec32.push_back(mk('h004, 0, 2, 0, 64'h0,        1, 0,   64'h0, 64'h80017FFF, 0, 2));
      vec32.push_back(mk('h007, 0, 1, 1, 64'h0,        1, 0,   64'h0, 64'h0, 1, 1));
      vec32.push_back(mk('h003, 1, 1, 0, 64'h5566,     0, 0,   64'h0, 64'h0, 1, 1));
      oldWord = 64'h80017FFF;
`else
      vec32.push_back(mk('h005, 1, 2, 0, 64'hDEADBEEF, 1, 'hF, 64'hDEADBEEF, 64'h0, 0, 1));
      vec32.push_back(mk('h004, 0, 2, 0, 64'h0,        1, 0,   64'h0, 64'hDEADBEEF, 0, 2));
      vec32.push_back(mk('h007, 0, 1, 1, 64'h0,        1, 0,   64'h0, 64'hFFFFDEAD, 0, 2));
      vec32.push_back(mk('h003, 1, 1, 0, 64'h5566,     0, 'hC, 64'h55665566, 64'h0, 0, 1));
      oldWord = 64'hDEADBEEF;
`endif

      vec64.push_back(mk('h008, 1, 3, 0, 64'h0123456789ABCDEF, 1, 'hFF, 64'h0123456789ABCDEF, 64'h0, 0, 1));
      vec64.push_back(mk('h008, 0, 3, 1, 64'h0, 1, 0, 64'h0, 64'h0123456789ABCDEF, 0, 2));
      vec64.push_back(mk('h00C, 0, 2, 1, 64'h0, 1, 0, 64'h0, 64'h0000000001234567, 0, 2));
      vec64.push_back(mk('h008, 0, 2, 1, 64'h0, 1, 0, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 2));
      vec64.push_back(mk('h00A, 0, 1, 1, 64'h0, 1, 0, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, 2));
      vec64.push_back(mk('h014, 1, 2, 0, 64'h76543210, 2, 'hF0, 64'h7654321076543210, 64'h0, 0, 1));
      vec64.push_back(mk('h012, 1, 1, 0, 64'hBEEF, 2, 'h0C, 64'hBEEFBEEFBEEFBEEF, 64'h0, 0, 1));
      vec64.push_back(mk('h014, 0, 2, 0, 64'h0, 2, 0, 64'h0, 64'h0000000076543210, 0, 2));
      vec64.push_back(mk('h012, 0, 1, 0, 64'h0, 2, 0, 64'h0, 64'h000000000000BEEF, 0, 2));
      vec64.push_back(mk('h012, 0, 1, 1, 64'h0, 2, 0, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0, 2));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset rsp_valid", 64'(curRspValid), 64'(0));
      checkOutput("reset rsp_rdata", curRspRdata, 64'h0);
      checkOutput("reset rsp_err", 64'(curRspErr), 64'(0));
      checkOutput("reset mem_wen", 64'(curMemWen), 64'(0));
      checkOutput("reset mem_addr", 64'(curMemAddr), 64'(0));
      checkOutput("reset req_ready", 64'(curReqReady), 64'(1));

      foreach (vec32[i]) applyStimulus($sformatf("v32_%0d", i), vec32[i]);

      // Response backpressure with a competing request parked on the input.
      bp = mk('h008, 0, 2, 0, 64'h0, 2, 0, 64'h0, 64'h1234F00D, 0, 2);
      @(posedge clk); #1;
      driveReq(bp);
      sbQ.push_back('{rdata: bp.expRdata, err: bp.expErr, lat: bp.expLat});
      @(posedge clk); #1;
      reqValid = 1'b0;
      waitRsp(lat);
      for (int k = 0; k < 5; k++) begin
         reqValid = 1'b1; reqWe = 1'b1; reqAddr = 14'h0040; reqSize = 2'd2;
         #1;
         checkOutput($sformatf("bp%0d rsp_valid", k), 64'(curRspValid), 64'(1));
         checkOutput($sformatf("bp%0d rdata", k), curRspRdata, 64'h1234F00D);
         checkOutput($sformatf("bp%0d req_ready", k), 64'(curReqReady), 64'(0));
         checkOutput($sformatf("bp%0d mem_addr", k), 64'(curMemAddr), 64'(2));
         checkOutput($sformatf("bp%0d mem_wen", k), 64'(curMemWen), 64'(0));
         @(posedge clk); #1;
      end
      reqValid = 1'b0;
      collectResponse("bp", lat);

      // Reset while a load waits for memory data, with a store offered during reset.
      @(posedge clk); #1;
      driveReq(mk('h004, 0, 2, 0, 64'h0, 1, 0, 64'h0, 64'h0, 0, 2));
      @(posedge clk); #1;
      reqValid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst rd_wait req_ready", 64'(curReqReady), 64'(0));
      checkOutput("rst rd_wait mem_wen", 64'(curMemWen), 64'(0));
      @(posedge clk); #1;
      driveReq(mk('h004, 1, 2, 0, 64'hFFFFFFFF, 1, 0, 64'h0, 64'h0, 0, 1));
      #1;
      checkOutput("rst store mem_wen", 64'(curMemWen), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      reqValid = 1'b0;
      #1;
      checkOutput("post rst rsp_valid", 64'(curRspValid), 64'(0));
      checkOutput("post rst mem_wen", 64'(curMemWen), 64'(0));
      checkOutput("post rst req_ready", 64'(curReqReady), 64'(1));
      applyStimulus("post rst reload", mk('h004, 0, 2, 0, 64'h0, 1, 0, 64'h0, oldWord, 0, 2));

      @(posedge clk); #1;
      use64 = 1'b1;
      foreach (vec64[i]) applyStimulus($sformatf("v64_%0d", i), vec64[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
